// File: rtl/pio_in.sv
// Read-side parallel I/O port: synchronizes and debounces board switches
// and buttons, latches sticky press/change events, and returns them to the
// CPU over a strobed register read with an event-pending interrupt.
module pio_in #(
  parameter int TICK_DIV = 500000,
  parameter int N_SW     = 16,
  parameter int N_BTN    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic [1:0]        addr,
  input  logic [N_SW-1:0]   SW_in,
  input  logic [N_BTN-1:0]  BTN_in,
  output logic [31:0]       PData_out,
  output logic              rd_valid,
  output logic              irq
);

  localparam int CW = $clog2(TICK_DIV);

  logic [N_SW-1:0]       sw_s1_q, sw_s2_q;
  logic [N_BTN-1:0]      btn_s1_q, btn_s2_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tick;
  logic [N_SW-1:0][2:0]  sw_hist_q, sw_hist_d;
  logic [N_BTN-1:0][2:0] btn_hist_q, btn_hist_d;
  logic [N_SW-1:0]       sw_stable_q, sw_stable_d;
  logic [N_BTN-1:0]      btn_stable_q, btn_stable_d;
  logic [N_BTN-1:0]      btn_event_q, btn_event_d;
  logic                  sw_chg_q, sw_chg_d;
  logic [N_BTN-1:0]      btn_clr;
  logic                  sw_clr;
  logic [31:0]           rd_data;
  logic [31:0]           pdata_d;
  logic                  irq_d;

  // Two-flop synchronizer on every raw input bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      sw_s1_q  <= SW_in;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= BTN_in;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Prescaler next count; tick marks the last count of each sample period
  always_comb begin
    tick  = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Debounce: shift synced level into history on tick, commit on 3 agreeing samples
  always_comb begin
    sw_hist_d    = sw_hist_q;
    sw_stable_d  = sw_stable_q;
    btn_hist_d   = btn_hist_q;
    btn_stable_d = btn_stable_q;
    if (tick) begin
      for (int i = 0; i < N_SW; i++) begin
        sw_hist_d[i] = {sw_hist_q[i][1:0], sw_s2_q[i]};
        if (sw_hist_d[i] == 3'b111)      sw_stable_d[i] = 1'b1;
        else if (sw_hist_d[i] == 3'b000) sw_stable_d[i] = 1'b0;
      end
      for (int i = 0; i < N_BTN; i++) begin
        btn_hist_d[i] = {btn_hist_q[i][1:0], btn_s2_q[i]};
        if (btn_hist_d[i] == 3'b111)      btn_stable_d[i] = 1'b1;
        else if (btn_hist_d[i] == 3'b000) btn_stable_d[i] = 1'b0;
      end
    end
  end

  // Read decode; read data reflects pre-update event state
  always_comb begin
    rd_data = '0;
    case (addr)
      2'd0: rd_data = {{(32-N_SW){1'b0}}, sw_stable_q};
      2'd1: rd_data = {{(32-N_BTN){1'b0}}, btn_event_q};
      2'd2: rd_data = {{(32-N_BTN){1'b0}}, btn_stable_q};
      2'd3: rd_data = {30'b0, sw_chg_q, |btn_event_q};
      default: rd_data = '0;
    endcase
    btn_clr = (EN && addr == 2'd1) ? btn_event_q : '0;
    sw_clr  = EN && (addr == 2'd3);
    pdata_d = EN ? rd_data : PData_out;
  end

  // Sticky events: set terms are OR'd after the clear so a new event is never lost
  always_comb begin
    btn_event_d = (btn_event_q & ~btn_clr) | (btn_stable_d & ~btn_stable_q);
    sw_chg_d    = (sw_chg_q & ~sw_clr) | (|(sw_stable_d ^ sw_stable_q));
    irq_d       = (|btn_event_q) | sw_chg_q;
  end

  // State, event and bus-output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      sw_hist_q    <= '0;
      btn_hist_q   <= '0;
      sw_stable_q  <= '0;
      btn_stable_q <= '0;
      btn_event_q  <= '0;
      sw_chg_q     <= 1'b0;
      PData_out    <= '0;
      rd_valid     <= 1'b0;
      irq          <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sw_hist_q    <= sw_hist_d;
      btn_hist_q   <= btn_hist_d;
      sw_stable_q  <= sw_stable_d;
      btn_stable_q <= btn_stable_d;
      btn_event_q  <= btn_event_d;
      sw_chg_q     <= sw_chg_d;
      PData_out    <= pdata_d;
      rd_valid     <= EN;
      irq          <= irq_d;
    end
  end

endmodule

// File: tb/tb_pio_in.sv
// Directed bench for pio_in with a 4-cycle debounce sample period.
module tb_pio_in;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic [1:0]  addr;
  logic [15:0] SW_in;
  logic [4:0]  BTN_in;
  logic [31:0] PData_out;
  logic        rd_valid;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  pio_in #(.TICK_DIV(4), .N_SW(16), .N_BTN(5)) dut (
    .clk(clk), .rst(rst), .EN(EN), .addr(addr), .SW_in(SW_in),
    .BTN_in(BTN_in), .PData_out(PData_out), .rd_valid(rd_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Two reset edges; returns just after the last one with rst low
  task automatic do_reset(input logic [15:0] sw, input logic [4:0] btn);
    rst = 1'b1; EN = 1'b0; addr = 2'd0; SW_in = sw; BTN_in = btn;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic v);
    EN = 1'b1; addr = a;
    step();
    d = PData_out; v = rd_valid;
    EN = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v; int n;
    do_reset(16'hFFFF, 5'h00);
    n_checks++; if (PData_out !== 32'h0) begin n_fail++; $display("FAIL reset_pdata got=%h exp=%h", PData_out, 32'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    n = 0;
    while (irq !== 1'b1 && n < 15) begin step(); n++; end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq_rise got=%b exp=1 after %0d cycles", irq, n); end
    rd(2'd0, d, v);
    n_checks++; if (d !== 32'h0000FFFF) begin n_fail++; $display("FAIL reset_sw_stable got=%h exp=%h", d, 32'h0000FFFF); end
    rd(2'd3, d, v);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", d, 32'h2); end
    rd(2'd3, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status_clr got=%h exp=%h", d, 32'h0); end
    step();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_fall got=%b exp=0", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] d; logic v; logic irq_seen;
    do_reset(16'h0000, 5'h00);
    steps(3);
    BTN_in = 5'b00001;
    steps(5);
    BTN_in = 5'b00000;
    irq_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); if (irq !== 1'b0) irq_seen = 1'b1; end
    n_checks++; if (irq_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_irq got=%b exp=0", irq_seen); end
    rd(2'd2, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_btn_stable got=%h exp=%h", d, 32'h0); end
    rd(2'd1, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_btn_event got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_clean_press();
    logic [31:0] d; logic v;
    do_reset(16'h0000, 5'h00);
    BTN_in = 5'b00100;
    steps(20);
    rd(2'd2, d, v);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL press_btn_stable got=%h exp=%h", d, 32'h4); end
    step(); step();
    n_checks++; if (PData_out !== 32'h4) begin n_fail++; $display("FAIL press_pdata_hold got=%h exp=%h", PData_out, 32'h4); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL press_irq got=%b exp=1", irq); end
    rd(2'd1, d, v);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL press_event got=%h exp=%h", d, 32'h4); end
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL press_rd_valid got=%b exp=1", v); end
    step();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL press_rd_valid_drop got=%b exp=0", rd_valid); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_fall got=%b exp=0", irq); end
    rd(2'd1, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL press_event_clr got=%h exp=%h", d, 32'h0); end
    BTN_in = 5'b00000;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2; logic v1, v2;
    do_reset(16'h0000, 5'h00);
    BTN_in = 5'b00001;
    steps(20);
    EN = 1'b1; addr = 2'd1;
    step(); d1 = PData_out; v1 = rd_valid;
    step(); d2 = PData_out; v2 = rd_valid;
    EN = 1'b0;
    step();
    n_checks++; if (d1 !== 32'h1) begin n_fail++; $display("FAIL b2b_first got=%h exp=%h", d1, 32'h1); end
    n_checks++; if (d2 !== 32'h0) begin n_fail++; $display("FAIL b2b_second got=%h exp=%h", d2, 32'h0); end
    n_checks++; if (v1 !== 1'b1 || v2 !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_valid got=%b%b exp=11", v1, v2); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_valid_drop got=%b exp=0", rd_valid); end
    BTN_in = 5'b00000;
  endtask

  // Button set at reset release: synced by E2, sampled at ticks E4/E8/E12,
  // so the stable rise and event set land on E12 after release.
  task automatic test_collision();
    logic [31:0] d; logic v;
    do_reset(16'h0000, 5'b00010);
    steps(11);
    rd(2'd1, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL collide_read got=%h exp=%h", d, 32'h0); end
    step();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL collide_irq got=%b exp=1", irq); end
    rd(2'd1, d, v);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL collide_event_kept got=%h exp=%h", d, 32'h2); end
    BTN_in = 5'b00000;
  endtask

  task automatic test_switch();
    logic [31:0] d; logic v;
    do_reset(16'h0000, 5'h00);
    steps(2);
    SW_in = 16'h00A5;
    steps(20);
    rd(2'd0, d, v);
    n_checks++; if (d !== 32'h000000A5) begin n_fail++; $display("FAIL sw_value got=%h exp=%h", d, 32'hA5); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL sw_irq got=%b exp=1", irq); end
    rd(2'd3, d, v);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL sw_status got=%h exp=%h", d, 32'h2); end
    rd(2'd3, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL sw_status_clr got=%h exp=%h", d, 32'h0); end
    step();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL sw_irq_fall got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic v;
    do_reset(16'h0000, 5'h00);
    BTN_in = 5'b10001;
    steps(20);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_irq_pending got=%b exp=1", irq); end
    rd(2'd2, d, v);
    n_checks++; if (d !== 32'h11) begin n_fail++; $display("FAIL mid_btn_stable got=%h exp=%h", d, 32'h11); end
    rst = 1'b1; BTN_in = 5'b00000;
    step();
    rst = 1'b0;
    step();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq_after_rst got=%b exp=0", irq); end
    rd(2'd1, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_event_after_rst got=%h exp=%h", d, 32'h0); end
  endtask

  initial begin
    rst = 1'b1; EN = 1'b0; addr = 2'd0; SW_in = '0; BTN_in = '0;
    test_reset();
    test_glitch();
    test_clean_press();
    test_back_to_back();
    test_collision();
    test_switch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
